// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl: run/step/halt/reset controller for the Pipeline, with a cycle counter and a stop snapshot.
module pipeline_debug_ctrl #(
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int          MAX_CYCLES   = 1024,
    parameter int          RESET_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_code,
    output logic        cmd_ready,
    input  logic [31:0] pc_addr_in,
    input  logic [31:0] pc_instr_in,
    output logic        pc_enable_out,
    output logic        pc_reset_out,
    output logic        busy,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] snap_pc,
    output logic [31:0] snap_instr,
    output logic        snap_valid
);
    typedef enum logic [2:0] {IDLE, RST, RUN, STEP, DONE} state_t;
    state_t      state_q;
    logic [31:0] rst_cnt_q, run_cnt_q, run_cnt_d, cycle_count_q, snap_pc_q, snap_instr_q;
    logic        halted_q, snap_valid_q, accept, is_halt, run_exit;
    assign accept    = cmd_valid && cmd_ready;
    assign is_halt   = pc_instr_in == HALT_INSTR;
    assign run_cnt_d = run_cnt_q + 32'd1;
    // watchdog counts enabled cycles of the current RUN only
    assign run_exit  = is_halt || (accept && cmd_code == 2'b00) || run_cnt_d == 32'(MAX_CYCLES);
    assign pc_enable_out = state_q == RUN || state_q == STEP;
    assign pc_reset_out  = state_q == RST;
    assign cmd_ready     = state_q == IDLE || state_q == RUN || state_q == DONE;
    assign busy          = state_q == RST || state_q == RUN || state_q == STEP;
    assign halted        = halted_q;
    assign cycle_count   = cycle_count_q;
    assign snap_pc       = snap_pc_q;
    assign snap_instr    = snap_instr_q;
    assign snap_valid    = snap_valid_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            run_cnt_q     <= '0;
            cycle_count_q <= '0;
            snap_pc_q     <= '0;
            snap_instr_q  <= '0;
            halted_q      <= 1'b0;
            snap_valid_q  <= 1'b0;
        end else begin
            snap_valid_q <= 1'b0;
            if (pc_enable_out) cycle_count_q <= cycle_count_q + 32'd1;
            case (state_q)
                IDLE, DONE: if (accept) begin
                    if (cmd_code == 2'b11) begin
                        state_q       <= RST;
                        rst_cnt_q     <= 32'(RESET_CYCLES - 1);
                        cycle_count_q <= '0;
                        halted_q      <= 1'b0;
                    end else if (cmd_code == 2'b01 && !halted_q) begin
                        state_q   <= RUN;
                        run_cnt_q <= '0;
                    end else if (cmd_code == 2'b10 && !halted_q) begin
                        state_q <= STEP;
                    end
                end
                RST: begin
                    if (rst_cnt_q == '0) state_q <= IDLE;
                    else rst_cnt_q <= rst_cnt_q - 32'd1;
                end
                RUN: begin
                    run_cnt_q <= run_cnt_d;
                    if (run_exit) begin
                        state_q      <= DONE;
                        snap_pc_q    <= pc_addr_in;
                        snap_instr_q <= pc_instr_in;
                        snap_valid_q <= 1'b1;
                        if (is_halt) halted_q <= 1'b1;
                    end
                end
                STEP: begin
                    state_q      <= DONE;
                    snap_pc_q    <= pc_addr_in;
                    snap_instr_q <= pc_instr_in;
                    snap_valid_q <= 1'b1;
                    if (is_halt) halted_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb_pipeline_debug_ctrl: directed vector table plus hand-written run/halt/watchdog/reset sequences.
module tb_pipeline_debug_ctrl;
    logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
    logic [1:0]  cmd_code = 2'b00;
    logic [31:0] pc_addr_in = '0, pc_instr_in = '0;
    logic        cmd_ready, pc_enable_out, pc_reset_out, busy, halted, snap_valid;
    logic [31:0] cycle_count, snap_pc, snap_instr;
    int          checks = 0, errors = 0;

    pipeline_debug_ctrl #(.HALT_INSTR(32'hFFFF_FFFF), .MAX_CYCLES(16), .RESET_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
        .pc_addr_in(pc_addr_in), .pc_instr_in(pc_instr_in), .pc_enable_out(pc_enable_out),
        .pc_reset_out(pc_reset_out), .busy(busy), .halted(halted), .cycle_count(cycle_count),
        .snap_pc(snap_pc), .snap_instr(snap_instr), .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, v;
        logic [1:0]  code;
        logic [31:0] addr, instr;
        logic        en, prst, rdy, bsy, hlt, sv;
        logic [31:0] cnt, spc;
    } vec_t;
    vec_t vec [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic v, input logic [1:0] code);
        cmd_valid = v;
        cmd_code  = code;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic reset_cmd();
        tick(1'b1, 2'b11);
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b00);
    endtask

    initial begin
        int n;
        //          rst  v    code   addr      instr    en   prst rdy  bsy  hlt  sv   cnt    spc
        vec[0]  = '{1'b1,1'b0,2'b00,32'h0,    32'h0,   1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd0,32'h0};
        vec[1]  = '{1'b0,1'b1,2'b11,32'h0,    32'h0,   1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'd0,32'h0};
        vec[2]  = '{1'b0,1'b0,2'b00,32'h0,    32'h0,   1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'd0,32'h0};
        vec[3]  = '{1'b0,1'b0,2'b00,32'h0,    32'h0,   1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd0,32'h0};
        vec[4]  = '{1'b0,1'b1,2'b10,32'h100,  32'h13,  1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'd0,32'h0};
        vec[5]  = '{1'b0,1'b0,2'b00,32'h104,  32'h13,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'd1,32'h104};
        vec[6]  = '{1'b0,1'b0,2'b00,32'h0,    32'h0,   1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd1,32'h104};
        vec[7]  = '{1'b0,1'b1,2'b10,32'h200,  32'h13,  1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'd1,32'h104};
        vec[8]  = '{1'b0,1'b0,2'b00,32'h204,  32'h13,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'd2,32'h204};
        vec[9]  = '{1'b0,1'b0,2'b00,32'h0,    32'h0,   1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd2,32'h204};
        vec[10] = '{1'b0,1'b1,2'b10,32'h300,  32'h13,  1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'd2,32'h204};
        vec[11] = '{1'b0,1'b0,2'b00,32'h304,  32'h13,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'd3,32'h304};
        for (int i = 0; i < 12; i++) begin
            reset       = vec[i].rst;
            pc_addr_in  = vec[i].addr;
            pc_instr_in = vec[i].instr;
            tick(vec[i].v, vec[i].code);
            chk($sformatf("v%0d_en", i),   32'(pc_enable_out), 32'(vec[i].en));
            chk($sformatf("v%0d_prst", i), 32'(pc_reset_out),  32'(vec[i].prst));
            chk($sformatf("v%0d_rdy", i),  32'(cmd_ready),     32'(vec[i].rdy));
            chk($sformatf("v%0d_busy", i), 32'(busy),          32'(vec[i].bsy));
            chk($sformatf("v%0d_halt", i), 32'(halted),        32'(vec[i].hlt));
            chk($sformatf("v%0d_sv", i),   32'(snap_valid),    32'(vec[i].sv));
            chk($sformatf("v%0d_cnt", i),  cycle_count,        vec[i].cnt);
            chk($sformatf("v%0d_spc", i),  snap_pc,            vec[i].spc);
        end
        reset = 1'b0;
        pc_instr_in = 32'h13;
        // run terminated by the halt instruction on the 10th enabled cycle
        reset_cmd();
        chk("pre_run_cnt", cycle_count, 32'd0);
        tick(1'b1, 2'b01);
        chk("run_en", 32'(pc_enable_out), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            pc_addr_in  = 32'h1000 + 32'(4 * k);
            pc_instr_in = (k == 10) ? 32'hFFFF_FFFF : 32'h13;
            if (k == 10) chk("run_en10", 32'(pc_enable_out), 32'd1);
            tick(1'b0, 2'b00);
        end
        pc_instr_in = 32'h13;
        chk("hi_en", 32'(pc_enable_out), 32'd0);
        chk("hi_halted", 32'(halted), 32'd1);
        chk("hi_cnt", cycle_count, 32'd10);
        chk("hi_sinstr", snap_instr, 32'hFFFF_FFFF);
        chk("hi_spc", snap_pc, 32'h1028);
        chk("hi_sv", 32'(snap_valid), 32'd1);
        tick(1'b1, 2'b01);
        chk("halted_run_en", 32'(pc_enable_out), 32'd0);
        chk("halted_run_rdy", 32'(cmd_ready), 32'd1);
        tick(1'b0, 2'b00);
        chk("halted_run_en2", 32'(pc_enable_out), 32'd0);
        tick(1'b1, 2'b11);
        chk("clr_halted", 32'(halted), 32'd0);
        chk("clr_cnt", cycle_count, 32'd0);
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b00);
        chk("clr_prst", 32'(pc_reset_out), 32'd0);
        // watchdog run
        tick(1'b1, 2'b01);
        n = 0;
        for (int i = 0; i < 40 && pc_enable_out; i++) begin
            n++;
            tick(1'b0, 2'b00);
        end
        chk("wd_len", 32'(n), 32'd16);
        chk("wd_cnt", cycle_count, 32'd16);
        chk("wd_halted", 32'(halted), 32'd0);
        chk("wd_sv", 32'(snap_valid), 32'd1);
        // CMD_HALT after 5 enabled cycles
        reset_cmd();
        tick(1'b1, 2'b01);
        repeat (4) tick(1'b0, 2'b00);
        chk("ch_en", 32'(pc_enable_out), 32'd1);
        tick(1'b1, 2'b00);
        chk("ch_en_off", 32'(pc_enable_out), 32'd0);
        chk("ch_cnt", cycle_count, 32'd5);
        chk("ch_halted", 32'(halted), 32'd0);
        chk("ch_rdy", 32'(cmd_ready), 32'd1);
        tick(1'b1, 2'b11);
        chk("ch_rst_cnt", cycle_count, 32'd0);
        chk("ch_rst_prst", 32'(pc_reset_out), 32'd1);
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b00);
        // reset mid-RUN together with a RUN command
        tick(1'b1, 2'b01);
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b00);
        reset = 1'b1;
        tick(1'b1, 2'b01);
        reset = 1'b0;
        chk("mr_en", 32'(pc_enable_out), 32'd0);
        chk("mr_cnt", cycle_count, 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rdy", 32'(cmd_ready), 32'd1);
        chk("mr_spc", snap_pc, 32'h0);
        chk("mr_sv", 32'(snap_valid), 32'd0);
        tick(1'b0, 2'b00);
        chk("mr_en2", 32'(pc_enable_out), 32'd0);
        // STEP onto the halt instruction sets halted, later STEP is dropped
        tick(1'b1, 2'b10);
        pc_instr_in = 32'hFFFF_FFFF;
        tick(1'b0, 2'b00);
        pc_instr_in = 32'h13;
        chk("sh_halted", 32'(halted), 32'd1);
        chk("sh_cnt", cycle_count, 32'd1);
        tick(1'b1, 2'b10);
        chk("sh_drop_en", 32'(pc_enable_out), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
